// File: rtl/bar_scroll_ctrl.sv
// Bouncing-bar scroll controller: steps the bar offset once every FRAMES_PER_STEP
// frames between 0 and OFF_MAX, gating the display enable only on frame boundaries.
module bar_scroll_ctrl #(
  parameter int H_LAST          = 524,
  parameter int V_LAST          = 285,
  parameter int OFF_MAX         = 460,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       clk_lcd,
  input  logic       rst_n,
  input  logic [9:0] hcount_reg,
  input  logic [8:0] Vcount_reg,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] step,
  input  logic       dir_init,
  output logic [9:0] offset,
  output logic       rgb_en,
  output logic       frame_tick,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

  state_t      state_r, state_next_s;
  logic [9:0]  offset_r, off_next_s;
  logic [7:0]  div_r, bounce_r;
  logic        dir_r, dir_next_s, hit_s;
  logic        rgb_en_r, frame_tick_r, busy_r;
  logic        boundary_s, accept_s, update_s;
  logic [10:0] sum_s;

  assign boundary_s = (hcount_reg == 10'(H_LAST)) && (Vcount_reg == 9'(V_LAST));
  assign accept_s   = (state_r == IDLE) && start && !stop;
  assign update_s   = (state_r == RUN) && boundary_s && (div_r == 8'(FRAMES_PER_STEP - 1));
  assign sum_s      = {1'b0, offset_r} + {7'b0, step};

  // Next-state selection; stop has priority over start and boundaries
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = ARMED; else state_next_s = IDLE;
      ARMED: begin
        if (stop)            state_next_s = IDLE;
        else if (boundary_s) state_next_s = RUN;
        else                 state_next_s = ARMED;
      end
      RUN:     if (stop) state_next_s = DRAIN; else state_next_s = RUN;
      DRAIN:   if (boundary_s) state_next_s = IDLE; else state_next_s = DRAIN;
      default: state_next_s = IDLE;
    endcase
  end

  // Offset/direction update with edge clamping; a zero step never bounces
  always_comb begin
    off_next_s = offset_r;
    dir_next_s = dir_r;
    hit_s      = 1'b0;
    if (step == 4'd0) begin
      off_next_s = offset_r;
    end else if (dir_r) begin
      if (sum_s >= 11'(OFF_MAX)) begin
        off_next_s = 10'(OFF_MAX);
        dir_next_s = 1'b0;
        hit_s      = 1'b1;
      end else begin
        off_next_s = sum_s[9:0];
      end
    end else begin
      if ({6'd0, step} >= offset_r) begin
        off_next_s = 10'd0;
        dir_next_s = 1'b1;
        hit_s      = 1'b1;
      end else begin
        off_next_s = offset_r - {6'd0, step};
      end
    end
  end

  // State, registered outputs and scroll datapath
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      offset_r     <= 10'd0;
      dir_r        <= 1'b1;
      bounce_r     <= 8'd0;
      div_r        <= 8'd0;
      rgb_en_r     <= 1'b0;
      frame_tick_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_tick_r <= boundary_s;
      busy_r       <= (state_next_s != IDLE);
      rgb_en_r     <= (state_next_s == RUN) || (state_next_s == DRAIN);
      if (accept_s) begin
        dir_r    <= dir_init;
        bounce_r <= 8'd0;
      end else if (update_s) begin
        offset_r <= off_next_s;
        dir_r    <= dir_next_s;
        if (hit_s && (bounce_r != 8'd255)) bounce_r <= bounce_r + 8'd1;
        else                               bounce_r <= bounce_r;
      end else begin
        offset_r <= offset_r;
      end
      if ((state_r == ARMED) && boundary_s) begin
        div_r <= 8'd0;
      end else if ((state_r == RUN) && boundary_s) begin
        if (div_r == 8'(FRAMES_PER_STEP - 1)) div_r <= 8'd0;
        else                                  div_r <= div_r + 8'd1;
      end else begin
        div_r <= div_r;
      end
    end
  end

  assign offset     = offset_r;
  assign rgb_en     = rgb_en_r;
  assign frame_tick = frame_tick_r;
  assign busy       = busy_r;
  assign bounce_cnt = bounce_r;

endmodule

// File: tb/tb_bar_scroll_ctrl.sv
// Directed bench for bar_scroll_ctrl: frame boundaries are injected directly on the
// counter inputs so whole scroll sequences run in a few hundred cycles.
module tb_bar_scroll_ctrl;
  localparam int H_LAST = 524;
  localparam int V_LAST = 285;

  logic       clk_lcd = 1'b0;
  logic       rst_n;
  logic [9:0] hcount_reg;
  logic [8:0] Vcount_reg;
  logic       start, stop, dir_init;
  logic [3:0] step;
  logic [9:0] offset;
  logic       rgb_en, frame_tick, busy;
  logic [7:0] bounce_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bar_scroll_ctrl #(.H_LAST(H_LAST), .V_LAST(V_LAST), .OFF_MAX(460), .FRAMES_PER_STEP(2)) dut (
    .clk_lcd(clk_lcd), .rst_n(rst_n), .hcount_reg(hcount_reg), .Vcount_reg(Vcount_reg),
    .start(start), .stop(stop), .step(step), .dir_init(dir_init),
    .offset(offset), .rgb_en(rgb_en), .frame_tick(frame_tick), .busy(busy),
    .bounce_cnt(bounce_cnt)
  );

  always #5 clk_lcd = ~clk_lcd;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_lcd);
    #1;
  endtask

  // one cycle on the frame boundary, then one ordinary cycle
  task automatic boundary();
    hcount_reg = 10'(H_LAST);
    Vcount_reg = 9'(V_LAST);
    tick();
    hcount_reg = 10'd0;
    Vcount_reg = 9'd0;
  endtask

  // two boundaries; the second is the update one, step may differ on each
  task automatic upd(input logic [3:0] s_first, input logic [3:0] s_upd);
    step = s_first;
    boundary();
    tick();
    step = s_upd;
    boundary();
    tick();
  endtask

  task automatic pulse_start(input logic d);
    dir_init = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hcount_reg = 10'd0; Vcount_reg = 9'd0;
    start = 1'b0; stop = 1'b0; step = 4'd0; dir_init = 1'b0;
    #1;
    check_val("reset_offset", int'(offset), 0);
    check_val("reset_rgb_en", int'(rgb_en), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_bounce", int'(bounce_cnt), 0);
    check_val("reset_tick", int'(frame_tick), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_val("collide_busy", int'(busy), 0);
    boundary();
    check_val("collide_rgb", int'(rgb_en), 0);
    check_val("tick_in_idle", int'(frame_tick), 1);
    tick();
    check_val("tick_one_cycle", int'(frame_tick), 0);

    // start then stop before any boundary: back to IDLE, never enabled
    pulse_start(1'b1);
    check_val("armed_busy", int'(busy), 1);
    check_val("armed_rgb", int'(rgb_en), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("armed_stop_busy", int'(busy), 0);
    boundary();
    check_val("armed_stop_rgb", int'(rgb_en), 0);
    tick();

    // basic scroll, step 5, right
    step = 4'd5;
    pulse_start(1'b1);
    tick();
    check_val("pre_boundary_rgb", int'(rgb_en), 0);
    boundary();                                 // b1: enter RUN
    check_val("b1_rgb", int'(rgb_en), 1);
    check_val("b1_offset", int'(offset), 0);
    tick();
    boundary(); tick();                         // b2
    check_val("b2_offset", int'(offset), 0);
    boundary();                                 // b3: update
    check_val("b3_offset", int'(offset), 5);
    check_val("b3_tick", int'(frame_tick), 1);
    tick();
    boundary(); tick();                         // b4
    check_val("b4_offset", int'(offset), 5);
    boundary(); tick();                         // b5
    boundary(); tick();                         // b6
    check_val("b6_offset", int'(offset), 10);
    boundary(); tick();                         // b7: update -> 15
    check_val("b7_offset", int'(offset), 15);

    // climb to 458: 15 + 31*14 = 449, then +9
    for (int i = 0; i < 31; i++) upd(4'd14, 4'd14);
    upd(4'd9, 4'd9);
    check_val("pre_right_edge", int'(offset), 458);
    check_val("pre_right_bounce", int'(bounce_cnt), 0);
    upd(4'd5, 4'd5);
    check_val("right_edge_offset", int'(offset), 460);
    check_val("right_edge_bounce", int'(bounce_cnt), 1);
    upd(4'd5, 4'd5);
    check_val("after_right_edge", int'(offset), 455);

    // descend to 3: 455 - 30*15 = 5, then -2
    for (int i = 0; i < 30; i++) upd(4'd15, 4'd15);
    upd(4'd2, 4'd2);
    check_val("pre_left_edge", int'(offset), 3);
    upd(4'd4, 4'd4);
    check_val("left_edge_offset", int'(offset), 0);
    check_val("left_edge_bounce", int'(bounce_cnt), 2);
    upd(4'd15, 4'd4);                           // only the update-cycle step counts
    check_val("step_sampled", int'(offset), 4);
    upd(4'd9, 4'd0);
    check_val("step0_offset", int'(offset), 4);
    check_val("step0_bounce", int'(bounce_cnt), 2);

    // stop mid-frame: drain until next boundary
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("drain_rgb", int'(rgb_en), 1);
    check_val("drain_busy", int'(busy), 1);
    tick();
    start = 1'b1;                               // ignored in DRAIN
    tick();
    start = 1'b0;
    boundary();
    check_val("drained_rgb", int'(rgb_en), 0);
    check_val("drained_busy", int'(busy), 0);
    check_val("drained_offset", int'(offset), 4);
    tick();

    // restart keeps offset, clears bounce count
    pulse_start(1'b1);
    check_val("restart_offset", int'(offset), 4);
    check_val("restart_bounce", int'(bounce_cnt), 0);
    boundary(); tick();
    for (int i = 0; i < 14; i++) upd(4'd14, 4'd14);
    check_val("pre_reset_offset", int'(offset), 200);
    boundary();                                 // frame_tick high, mid-frame reset follows
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_offset", int'(offset), 0);
    check_val("async_rgb", int'(rgb_en), 0);
    check_val("async_busy", int'(busy), 0);
    check_val("async_tick", int'(frame_tick), 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    check_val("post_reset_busy", int'(busy), 0);
    boundary();
    check_val("post_reset_rgb", int'(rgb_en), 0);
    check_val("post_reset_busy2", int'(busy), 0);
    check_val("post_reset_offset", int'(offset), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bar_scroll_ctrl.md
BAR_SCROLL_CTRL -- requirements
Module: bar_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter H_LAST, default 524, meaning the last hcount_reg value of a line.
REQ-002 The block SHALL have parameter V_LAST, default 285, meaning the last Vcount_reg value of a frame.
REQ-003 The block SHALL have parameter OFF_MAX, default 460, meaning the maximum bar offset (480 active pixels minus 20-pixel bar).
REQ-004 The block SHALL have parameter FRAMES_PER_STEP, default 2, range 1..255, meaning frame boundaries per offset update.
REQ-005 The block SHALL have port clk_lcd, input, 1 bit: LCD pixel clock; the only clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port hcount_reg, input, 10 bits: current horizontal pixel count.
REQ-008 The block SHALL have port Vcount_reg, input, 9 bits: current line count.
REQ-009 The block SHALL have port start, input, 1 bit: one-cycle request to begin scrolling.
REQ-010 The block SHALL have port stop, input, 1 bit: one-cycle request to end scrolling.
REQ-011 The block SHALL have port step, input, 4 bits: pixels moved per update; 0 holds position.
REQ-012 The block SHALL have port dir_init, input, 1 bit: starting direction (1 = right, 0 = left), sampled on accepted start.
REQ-013 The block SHALL have port offset, output, 10 bits: bar left edge for the drawing block.
REQ-014 The block SHALL have port rgb_en, output, 1 bit: enables the display output register.
REQ-015 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse per frame boundary.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port bounce_cnt, output, 8 bits: number of edge reversals, saturating at 255.

Function
REQ-018 The frame boundary SHALL be the cycle in which hcount_reg==H_LAST and Vcount_reg==V_LAST; frame_tick SHALL be registered high in the following cycle only.
REQ-019 The block SHALL implement the states IDLE, ARMED, RUN and DRAIN, all transitions registered on clk_lcd.
REQ-020 In IDLE, the block SHALL transition to ARMED on start; busy SHALL assert one cycle after start is sampled.
REQ-021 In ARMED, the block SHALL transition to RUN on the next frame boundary, set rgb_en=1 and clear the frame divider; enable SHALL never change mid-frame.
REQ-022 In RUN, a frame divider SHALL count frame boundaries 0..FRAMES_PER_STEP-1; on the boundary where the count equals FRAMES_PER_STEP-1, offset SHALL update in the same cycle that frame_tick asserts, and the divider SHALL wrap to 0.
REQ-023 The step input SHALL be sampled only on the update cycle.
REQ-024 Right-direction update: next = offset + step, computed at 11 bits; if next >= OFF_MAX then offset = OFF_MAX, direction flips to left and bounce_cnt increments.
REQ-025 Left-direction update: if step >= offset then offset = 0, direction flips to right and bounce_cnt increments; otherwise offset = offset - step.
REQ-026 With step=0, offset SHALL hold, no flip SHALL occur, and bounce_cnt SHALL hold, including when offset is at 0 or OFF_MAX.
REQ-027 offset SHALL never exceed OFF_MAX, in any state.
REQ-028 In RUN, stop SHALL transition the block to DRAIN; in DRAIN, the next frame boundary SHALL clear rgb_en and transition to IDLE, with offset held and no update on that boundary.
REQ-029 In ARMED, stop SHALL transition directly to IDLE; rgb_en SHALL remain 0.
REQ-030 When start and stop are asserted in the same cycle, stop SHALL win: IDLE stays IDLE, and RUN goes to DRAIN.
REQ-031 start SHALL be ignored in ARMED, RUN and DRAIN; stop SHALL be ignored in IDLE and DRAIN.
REQ-032 offset, direction and bounce_cnt SHALL retain their values across IDLE; on an accepted start, direction SHALL load from dir_init and bounce_cnt SHALL clear to 0.
REQ-033 frame_tick SHALL pulse on every frame boundary in all states.

Reset
REQ-034 While rst_n=0, regardless of clock, the block SHALL force state=IDLE, offset=0, rgb_en=0, frame_tick=0, busy=0, bounce_cnt=0, direction=right and frame divider=0.
REQ-035 Reset asserted mid-RUN SHALL abort immediately with the REQ-034 values; after release, the block SHALL remain in IDLE until a new start.

Verification
REQ-036 Scenario basic scroll: start with dir_init=1, step=5, FRAMES_PER_STEP=2 -> rgb_en=1 at the first boundary; offset 0,5,10 after boundaries 2,4,6 (counted after RUN entry).
REQ-037 Scenario right edge: offset=458, step=5, moving right -> offset=460, direction left, bounce_cnt=1; next update -> offset=455.
REQ-038 Scenario left edge: offset=3, step=4, moving left -> offset=0, direction right, bounce_cnt increments.
REQ-039 Scenario stop drain: stop mid-frame in RUN -> rgb_en stays 1 until the next boundary, then 0; busy falls the same cycle; offset unchanged.
REQ-040 Scenario collision and arming: start and stop asserted together in IDLE -> no state change; start then stop before a boundary -> IDLE, rgb_en never 1.
REQ-041 Scenario reset mid-frame: rst_n low for 3 cycles during RUN with offset=200 -> all outputs 0 asynchronously, state IDLE after release.
